// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART receiver
//
// Purpose: receiver state encoding, frame width and the default bit period.
// Ports:   none (package).
package uart_pkg;

  localparam int DATA_BITS            = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 217;  // 25 MHz / 115200 baud

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK_WAIT
  } rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial line and byte-output bundle of the UART receiver
//
// Purpose: groups the serial input with the received-byte outputs.
// Signals: i_RX          serial line, idle high
//          o_Data        last correctly framed byte
//          o_Valid       one-cycle strobe, o_Data updated in the same cycle
//          o_Frame_Error one-cycle strobe, stop bit sampled low
//          o_Busy        receiver not in IDLE
// Modports: slave  - the receiver
//           master - the line driver / byte consumer
interface uart_rx_if;
  import uart_pkg::*;

  logic                 i_RX;
  logic [DATA_BITS-1:0] o_Data;
  logic                 o_Valid;
  logic                 o_Frame_Error;
  logic                 o_Busy;

  modport slave (
    input  i_RX,
    output o_Data,
    output o_Valid,
    output o_Frame_Error,
    output o_Busy
  );

  modport master (
    output i_RX,
    input  o_Data,
    input  o_Valid,
    input  o_Frame_Error,
    input  o_Busy
  );

endinterface

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchroniser for the asynchronous RX line
//
// Purpose: brings the serial line into the i_Clock domain; output lags by 2 clocks.
// Ports:   i_Clock  system clock
//          i_Reset  asynchronous active-high reset (flops reset to idle-high)
//          rx       asynchronous serial input
//          rx_s     synchronised serial line
module uart_rx_sync (
  input  logic i_Clock,
  input  logic i_Reset,
  input  logic rx,
  output logic rx_s
);

  logic meta;

  // Reset to 1 so a reset never looks like a falling start edge.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      meta <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      meta <= rx;
      rx_s <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit sampling and framing check
//
// Purpose: detects a start bit, samples 8 data bits LSB first at mid-bit,
//          checks the stop bit and strobes either o_Valid or o_Frame_Error.
// Ports:   i_Clock  system clock, all state on rising edge
//          i_Reset  asynchronous active-high reset
//          rx_if    uart_rx_if.slave: i_RX in; o_Data, o_Valid,
//                   o_Frame_Error, o_Busy out
// Parameter CLKS_PER_BIT: clocks per bit, must be >= 4.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic     i_Clock,
  input  logic     i_Reset,
  uart_rx_if.slave rx_if
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CW       = $clog2(CLKS_PER_BIT);

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t     HALF_LAST = cnt_t'(HALF_BIT - 1);
  localparam cnt_t     BIT_LAST  = cnt_t'(CLKS_PER_BIT - 1);
  localparam logic [2:0] IDX_LAST = 3'(DATA_BITS - 1);

  logic rx_s;

  rx_state_t            state, state_n;
  cnt_t                 cnt, cnt_n;
  logic [2:0]           idx, idx_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic [DATA_BITS-1:0] data, data_n;
  logic                 valid, valid_n;
  logic                 ferr, ferr_n;

  uart_rx_sync u_sync (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .rx      (rx_if.i_RX),
    .rx_s    (rx_s)
  );

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
      data  <= '0;
      valid <= 1'b0;
      ferr  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      shift <= shift_n;
      data  <= data_n;
      valid <= valid_n;
      ferr  <= ferr_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shift_n = shift;
    data_n  = data;
    valid_n = 1'b0;
    ferr_n  = 1'b0;

    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_n = START;
          cnt_n   = '0;
        end
      end

      // Re-check the line half a bit in: a short low pulse is a glitch.
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_n = '0;
          if (!rx_s) begin
            state_n = DATA;
            idx_n   = '0;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt + cnt_t'(1);
        end
      end

      // Counter is now phase-aligned to mid-bit, so every full period
      // lands in the middle of the next bit.
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_n          = '0;
          shift_n[idx]   = rx_s;
          if (idx == IDX_LAST) begin
            state_n = STOP;
          end else begin
            idx_n = idx + 3'd1;
          end
        end else begin
          cnt_n = cnt + cnt_t'(1);
        end
      end

      // Leaving at mid-stop-bit leaves half a bit of slack for the next
      // start edge of a back-to-back frame.
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_n = '0;
          if (rx_s) begin
            data_n  = shift;
            valid_n = 1'b1;
            state_n = IDLE;
          end else begin
            ferr_n  = 1'b1;
            state_n = BREAK_WAIT;
          end
        end else begin
          cnt_n = cnt + cnt_t'(1);
        end
      end

      // A held-low line (break) must go high before a new start is accepted.
      BREAK_WAIT: begin
        if (rx_s) begin
          state_n = IDLE;
        end
      end

      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  assign rx_if.o_Data        = data;
  assign rx_if.o_Valid       = valid;
  assign rx_if.o_Frame_Error = ferr;
  assign rx_if.o_Busy        = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx with an event scoreboard
module tb_uart_rx;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;
  localparam int LAT  = 9 * CPB + HALF + 3;

  typedef struct {
    bit         err;
    logic [7:0] data;
    int         cyc;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  logic [7:0] last_good = 8'h00;
  ev_t  exp_q[$];
  ev_t  got_q[$];

  uart_rx_if u_if ();

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock (clk),
    .i_Reset (rst),
    .rx_if   (u_if)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && (u_if.o_Valid || u_if.o_Frame_Error)) begin
      chk("valid_ferr_exclusive", 32'(u_if.o_Valid & u_if.o_Frame_Error), 32'd0);
      got_q.push_back('{err: u_if.o_Frame_Error, data: u_if.o_Data, cyc: cyc});
    end
  end

  task automatic hold(input logic v, input int n);
    u_if.i_RX = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_ev(input bit err, input logic [7:0] d);
    exp_q.push_back('{err: err, data: d, cyc: cyc});
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_val, input int stop_clks);
    hold(1'b0, CPB);
    for (int i = 0; i < 8; i++) hold(b[i], CPB);
    hold(stop_val, stop_clks);
  endtask

  task automatic good_frame(input logic [7:0] b);
    expect_ev(1'b0, b);
    send_frame(b, 1'b1, CPB);
    last_good = b;
  endtask

  task automatic drain(input string tag);
    int   budget;
    ev_t  e;
    ev_t  g;
    budget = 0;
    while (got_q.size() < exp_q.size() && budget < 12 * CPB) begin
      @(posedge clk);
      budget++;
    end
    repeat (4) @(posedge clk);
    #1;
    chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      chk({tag, "_kind"}, 32'(g.err), 32'(e.err));
      chk({tag, "_data"}, 32'(g.data), 32'(e.data));
      chk({tag, "_latency"}, 32'(g.cyc - e.cyc), 32'(LAT));
    end
    exp_q.delete();
    got_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int t0;
    int n;

    // 1: reset state
    u_if.i_RX = 1'b1;
    rst = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("rst_data", 32'(u_if.o_Data), 32'h00);
    chk("rst_valid", 32'(u_if.o_Valid), 32'd0);
    chk("rst_ferr", 32'(u_if.o_Frame_Error), 32'd0);
    chk("rst_busy", 32'(u_if.o_Busy), 32'd0);
    rst = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    chk("idle_busy", 32'(u_if.o_Busy), 32'd0);
    drain("idle");

    // 2: single frame with latency check
    good_frame(8'h55);
    hold(1'b1, 2 * CPB);
    drain("f55");
    chk("f55_out", 32'(u_if.o_Data), 32'h55);

    // 3: back-to-back frames, stop bit exactly one bit time
    good_frame(8'hA3);
    good_frame(8'h0F);
    hold(1'b1, 2 * CPB);
    chk("b2b_events", 32'(got_q.size()), 32'd2);
    if (got_q.size() == 2)
      chk("b2b_spacing", 32'(got_q[1].cyc - got_q[0].cyc), 32'(10 * CPB));
    drain("b2b");
    chk("b2b_out", 32'(u_if.o_Data), 32'h0F);

    // 4: short low glitch is rejected
    hold(1'b0, 4);
    chk("glitch_busy_high", 32'(u_if.o_Busy), 32'd1);
    u_if.i_RX = 1'b1;
    n = 0;
    while (u_if.o_Busy && n < HALF + 3) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("glitch_busy_clear", 32'(u_if.o_Busy), 32'd0);
    hold(1'b1, CPB);
    drain("glitch");
    good_frame(8'h3C);
    hold(1'b1, 2 * CPB);
    drain("f3C");

    // 5: framing error with break held for 3 bit times
    expect_ev(1'b1, last_good);
    send_frame(8'hFF, 1'b0, 3 * CPB);
    chk("break_busy", 32'(u_if.o_Busy), 32'd1);
    chk("break_data_kept", 32'(u_if.o_Data), 32'(last_good));
    hold(1'b1, 4);
    chk("break_release_busy", 32'(u_if.o_Busy), 32'd0);
    hold(1'b1, CPB);
    drain("ferr");
    good_frame(8'h12);
    hold(1'b1, 2 * CPB);
    drain("f12");

    // 6: reset mid-frame discards the partial byte
    hold(1'b0, CPB);
    for (int i = 0; i < 4; i++) hold(i == 0 ? 1'b1 : 1'b0, CPB);
    u_if.i_RX = 1'b1;
    rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(u_if.o_Busy), 32'd0);
    chk("midrst_valid", 32'(u_if.o_Valid), 32'd0);
    chk("midrst_data", 32'(u_if.o_Data), 32'h00);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    t0 = cyc;
    hold(1'b1, 2 * CPB);
    chk("midrst_quiet_cycles", 32'(cyc - t0), 32'(2 * CPB));
    drain("midrst");
    good_frame(8'h81);
    hold(1'b1, 2 * CPB);
    drain("f81");
    chk("f81_out", 32'(u_if.o_Data), 32'h81);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
